// File: rtl/mac_feed_ctrl.sv
// Operand sequencer feeding a sequential multiply-accumulator: buffers (a, b) pairs in a
// small FIFO and issues exactly len pairs per vector, framed by acc_clr and done pulses.
module mac_feed_ctrl #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int LENW  = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [LENW-1:0]  len_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    output logic [WIDTH-1:0] mac_a_o,
    output logic [WIDTH-1:0] mac_b_o,
    output logic             mac_en_o,
    output logic             acc_clr_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [LENW-1:0]     rem_q;
    logic [WIDTH-1:0]    mac_a_q;
    logic [WIDTH-1:0]    mac_b_q;
    logic                mac_en_q;
    logic                acc_clr_q;
    logic                busy_q;
    logic                done_q;

    logic [2*WIDTH-1:0]  mem_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [2*WIDTH-1:0]  head;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;

    assign full       = (count_q == DEPTH_C);
    assign empty      = (count_q == '0);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;
    assign pop        = (state_q == S_RUN) && !empty && (rem_q != '0);
    assign head       = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
            mac_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            mac_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        rem_q     <= len_i;
                        acc_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLR;
                    end
                end
                S_CLR: begin
                    if (rem_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    // An empty FIFO simply leaves a bubble; rem is held until data arrives.
                    if (pop) begin
                        mac_a_q  <= head[2*WIDTH-1:WIDTH];
                        mac_b_q  <= head[WIDTH-1:0];
                        mac_en_q <= 1'b1;
                        rem_q    <= rem_q - LENW'(1);
                        if (rem_q == LENW'(1)) begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mac_a_o   = mac_a_q;
    assign mac_b_o   = mac_b_q;
    assign mac_en_o  = mac_en_q;
    assign acc_clr_o = acc_clr_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule
